// File: rtl/codec_seq_pkg.sv
// rtl/codec_seq_pkg.sv - shared state types and frame-size constants for the codec UART sequencer
package codec_seq_pkg;

   localparam int MAX_FRAME_BYTES = 8;
   localparam int MAX_IN_BITS     = 8 * MAX_FRAME_BYTES;
   localparam int MAX_OUT_BITS    = 2 * MAX_IN_BITS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_ENCODE,
      ST_SEND
   } seq_state_t;

   // Per-bit encoder handshake: clear pulse, bit issue, pair capture
   typedef enum logic [1:0] {
      ENC_CLEAR,
      ENC_ISSUE,
      ENC_CAPTURE
   } enc_phase_t;

   // Per-byte transmit handshake with the UART transmitter
   typedef enum logic [1:0] {
      TX_READY,
      TX_START,
      TX_GUARD,
      TX_WAIT
   } tx_phase_t;

endpackage

// File: rtl/codec_seq_bitpacker.sv
// rtl/codec_seq_bitpacker.sv - serializes the received frame LSB-first and packs encoder pairs into output bytes
module codec_seq_bitpacker
   import codec_seq_pkg::*;
#(
   parameter int FRAME_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic [MAX_IN_BITS-1:0]  in_buf,
   input  logic                    take,
   input  logic                    capture,
   input  logic [1:0]              pair,
   input  logic [3:0]              rd_idx,
   output logic                    cur_bit,
   output logic                    last_capture,
   output logic [7:0]              rd_byte
);

   localparam logic [5:0] LAST_BIT = 6'(8 * FRAME_BYTES - 1);

   // bit_idx is the next bit to issue; it may wrap after the final issue,
   // which is harmless because nothing is issued again before the next clear.
   logic [5:0]              bit_idx;
   logic [5:0]              cap_idx;
   logic [MAX_OUT_BITS-1:0] out_buf;

   assign cur_bit      = in_buf[bit_idx];
   assign last_capture = (cap_idx == LAST_BIT);
   assign rd_byte      = out_buf[{rd_idx, 3'b000} +: 8];

   // Advance the issue pointer on each take and store each encoder pair at its step slot
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         bit_idx <= '0;
         cap_idx <= '0;
         out_buf <= '0;
      end else begin
         if (take) begin
            bit_idx <= bit_idx + 6'd1;
         end
         if (capture) begin
            out_buf[{cap_idx, 1'b0} +: 2] <= pair;
            cap_idx                       <= cap_idx + 6'd1;
         end
      end
   end

endmodule

// File: rtl/codec_uart_sequencer.sv
// rtl/codec_uart_sequencer.sv - UART frame collect/encode/send sequencer (optional COLLECT timeout via CODEC_SEQ_TIMEOUT_EN)
module codec_uart_sequencer
   import codec_seq_pkg::*;
#(
   parameter int FRAME_BYTES    = 4,
   parameter int CONSTRAINT_LEN = 3,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_data_ready,
   input  logic [7:0] rx_data,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       enc_clear,
   output logic       enc_valid,
   output logic       enc_bit,
   input  logic [1:0] enc_out,
   output logic [2:0] k_sel,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);

   localparam logic [3:0] LAST_IN_BYTE  = 4'(FRAME_BYTES - 1);
   localparam logic [3:0] LAST_OUT_BYTE = 4'(2 * FRAME_BYTES - 1);

   seq_state_t             state;
   enc_phase_t             enc_phase;
   tx_phase_t              tx_phase;
   logic [3:0]             count;
   logic [3:0]             tx_idx;
   logic [MAX_IN_BITS-1:0] in_buf;
   logic                   take;
   logic                   capture;
   logic                   cur_bit;
   logic                   last_capture;
   logic [7:0]             rd_byte;
`ifdef CODEC_SEQ_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0]            tmo_cnt;
`endif

   assign k_sel = 3'(CONSTRAINT_LEN);
   assign busy  = (state != ST_IDLE);

   // A bit is taken when the clear cycle ends and after every capture except the last
   assign take    = (state == ST_ENCODE) &&
                    ((enc_phase == ENC_CLEAR) ||
                     ((enc_phase == ENC_CAPTURE) && !last_capture));
   assign capture = (state == ST_ENCODE) && (enc_phase == ENC_CAPTURE);

   codec_seq_bitpacker #(
      .FRAME_BYTES (FRAME_BYTES)
   ) u_bitpacker (
      .clk          (clk),
      .rst          (rst),
      .clear        (state == ST_IDLE),
      .in_buf       (in_buf),
      .take         (take),
      .capture      (capture),
      .pair         (enc_out),
      .rd_idx       (tx_idx),
      .cur_bit      (cur_bit),
      .last_capture (last_capture),
      .rd_byte      (rd_byte)
   );

   // Frame sequencer: collect bytes, drive the encoder bit by bit, then hand bytes to the UART
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         enc_phase  <= ENC_CLEAR;
         tx_phase   <= TX_READY;
         count      <= '0;
         tx_idx     <= '0;
         in_buf     <= '0;
         tx_start   <= 1'b0;
         tx_data    <= '0;
         enc_clear  <= 1'b0;
         enc_valid  <= 1'b0;
         enc_bit    <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
`ifdef CODEC_SEQ_TIMEOUT_EN
         tmo_cnt    <= '0;
`endif
      end else begin
         tx_start   <= 1'b0;
         enc_clear  <= 1'b0;
         enc_valid  <= 1'b0;
         frame_done <= 1'b0;

         // Bytes arriving while the frame is being processed are lost
         if (rx_data_ready && ((state == ST_ENCODE) || (state == ST_SEND))) begin
            overrun <= 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (rx_data_ready) begin
                  in_buf[7:0] <= rx_data;
                  count       <= 4'd1;
`ifdef CODEC_SEQ_TIMEOUT_EN
                  tmo_cnt     <= '0;
`endif
                  if (FRAME_BYTES == 1) begin
                     state     <= ST_ENCODE;
                     enc_phase <= ENC_CLEAR;
                     enc_clear <= 1'b1;
                  end else begin
                     state <= ST_COLLECT;
                  end
               end
            end

            ST_COLLECT: begin
               if (rx_data_ready) begin
                  in_buf[{count[2:0], 3'b000} +: 8] <= rx_data;
                  count                             <= count + 4'd1;
`ifdef CODEC_SEQ_TIMEOUT_EN
                  tmo_cnt                           <= '0;
`endif
                  if (count == LAST_IN_BYTE) begin
                     state     <= ST_ENCODE;
                     enc_phase <= ENC_CLEAR;
                     enc_clear <= 1'b1;
                  end
               end
`ifdef CODEC_SEQ_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  state   <= ST_IDLE;
                  count   <= '0;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
`endif
            end

            ST_ENCODE: begin
               case (enc_phase)
                  ENC_CLEAR: begin
                     enc_valid <= 1'b1;
                     enc_bit   <= cur_bit;
                     enc_phase <= ENC_ISSUE;
                  end
                  ENC_ISSUE: begin
                     enc_phase <= ENC_CAPTURE;
                  end
                  ENC_CAPTURE: begin
                     if (last_capture) begin
                        state    <= ST_SEND;
                        tx_phase <= TX_READY;
                        tx_idx   <= '0;
                     end else begin
                        enc_valid <= 1'b1;
                        enc_bit   <= cur_bit;
                        enc_phase <= ENC_ISSUE;
                     end
                  end
                  default: begin
                     enc_phase <= ENC_CLEAR;
                  end
               endcase
            end

            ST_SEND: begin
               case (tx_phase)
                  TX_READY: begin
                     if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= rd_byte;
                        tx_phase <= TX_START;
                     end
                  end
                  // The transmitter has not reacted to the request yet; its busy is stale here
                  TX_START: begin
                     tx_phase <= TX_GUARD;
                  end
                  TX_GUARD: begin
                     tx_phase <= TX_WAIT;
                  end
                  TX_WAIT: begin
                     if (!tx_busy) begin
                        if (tx_idx == LAST_OUT_BYTE) begin
                           frame_done <= 1'b1;
                           state      <= ST_IDLE;
                           count      <= '0;
                        end else begin
                           tx_idx   <= tx_idx + 4'd1;
                           tx_phase <= TX_READY;
                        end
                     end
                  end
                  default: begin
                     tx_phase <= TX_READY;
                  end
               endcase
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_codec_uart_sequencer.sv
// tb/tb_codec_uart_sequencer.sv - self-checking bench for codec_uart_sequencer
module tb_codec_uart_sequencer;

   localparam int FB   = 4;
   localparam int NOUT = 2 * FB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_data_ready = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       enc_clear;
   logic       enc_valid;
   logic       enc_bit;
   logic [1:0] enc_out = 2'b00;
   logic [2:0] k_sel;
   logic       busy;
   logic       frame_done;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int         tx_cnt = 0;
   int         done_cnt = 0;
   int         valid_cnt = 0;
   int         clear_cnt = 0;
   int         busy_hold = 0;
   int         bcnt = 0;
   logic [7:0] held_data = 8'h00;

   typedef struct packed {
      logic [3:0][7:0] din;
      logic [7:0][7:0] dout;
      int              hold;
   } vec_t;

   vec_t vecs[4];

   codec_uart_sequencer #(
      .FRAME_BYTES    (FB),
      .CONSTRAINT_LEN (3),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rx_data_ready (rx_data_ready),
      .rx_data       (rx_data),
      .tx_busy       (tx_busy),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .enc_clear     (enc_clear),
      .enc_valid     (enc_valid),
      .enc_bit       (enc_bit),
      .enc_out       (enc_out),
      .k_sel         (k_sel),
      .busy          (busy),
      .frame_done    (frame_done),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Encoder stub: pair = {bit,bit} one cycle after enc_valid, zero otherwise
   always @(posedge clk) begin
      enc_out <= (!rst && enc_valid) ? {enc_bit, enc_bit} : 2'b00;
   end

   // Transmitter stub: busy for busy_hold cycles starting the cycle after tx_start
   always @(posedge clk) begin
      if (rst) bcnt <= 0;
      else if (tx_start) bcnt <= busy_hold;
      else if (bcnt > 0) bcnt <= bcnt - 1;
   end
   assign tx_busy = (bcnt != 0);

   // Output monitor and scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (enc_valid) valid_cnt++;
         if (enc_clear) clear_cnt++;
         if (frame_done) done_cnt++;
         if (tx_busy) check("tx_data_stable", tx_data, held_data);
         if (tx_start) begin
            tx_cnt++;
            held_data = tx_data;
            check("tx_start_not_busy", tx_busy, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected: got 0x%0h, expected no transmit", tx_data);
            end else begin
               check("tx_byte", tx_data, exp_q.pop_front());
            end
         end
      end
   end

   function automatic vec_t mk(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3,
                               input logic [63:0] outs, input int hold);
      vec_t v;
      v.din[0] = b0;
      v.din[1] = b1;
      v.din[2] = b2;
      v.din[3] = b3;
      for (int n = 0; n < NOUT; n++) v.dout[n] = outs[63 - 8*n -: 8];
      v.hold = hold;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data_ready = 1'b1;
      rx_data       = b;
      @(posedge clk); #1;
      rx_data_ready = 1'b0;
   endtask

   task automatic push_exp(input int i);
      for (int n = 0; n < NOUT; n++) exp_q.push_back(vecs[i].dout[n]);
   endtask

   task automatic wait_done(input int d0, input int budget);
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("frame_done_seen", done_cnt - d0, 1);
   endtask

   task automatic run_vector(input int i);
      int d0 = done_cnt;
      int t0 = tx_cnt;
      int v0 = valid_cnt;
      int c0 = clear_cnt;
      busy_hold = vecs[i].hold;
      push_exp(i);
      for (int k = 0; k < FB; k++) send_byte(vecs[i].din[k]);
      wait_done(d0, 5000);
      check("busy_after_done", busy, 0);
      check("tx_count", tx_cnt - t0, NOUT);
      check("enc_valid_count", valid_cnt - v0, 8 * FB);
      check("enc_clear_count", clear_cnt - c0, 1);
      check("scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("busy_after_rst", busy, 0);
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, v0, d0, n;

      vecs[0] = mk(8'h01, 8'h00, 8'h00, 8'h00, 64'h03_00_00_00_00_00_00_00, 0);
      vecs[1] = mk(8'hFF, 8'hA5, 8'h00, 8'h0F, 64'hFF_FF_33_CC_00_00_FF_00, 3);
      vecs[2] = mk(8'h12, 8'h34, 8'h56, 8'h78, 64'h0C_03_30_0F_3C_33_C0_3F, 1);
      vecs[3] = mk(8'h80, 8'h01, 8'h7E, 8'hC3, 64'h00_C0_03_00_FC_3F_0F_F0, 100);

      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_enc_clear", enc_clear, 0);
      check("rst_enc_valid", enc_valid, 0);
      check("rst_enc_bit", enc_bit, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_overrun", overrun, 0);
      check("k_sel", k_sel, 3);

      for (int i = 0; i < 4; i++) run_vector(i);
      check("no_spurious_overrun", overrun, 0);

      // Fifth byte while sending is dropped and flagged, frame unaffected
      busy_hold = 5;
      push_exp(1);
      d0 = done_cnt;
      t0 = tx_cnt;
      for (int k = 0; k < FB; k++) send_byte(vecs[1].din[k]);
      n = 0;
      while (tx_cnt == t0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("overrun_reached_send", (tx_cnt > t0), 1);
      send_byte(8'hAA);
      @(negedge clk);
      check("overrun_set", overrun, 1);
      wait_done(d0, 5000);
      check("overrun_tx_count", tx_cnt - t0, NOUT);
      check("overrun_sticky", overrun, 1);
      check("overrun_scoreboard", exp_q.size(), 0);
      pulse_rst();
      @(negedge clk);
      check("overrun_cleared_by_rst", overrun, 0);

      // Reset after two collected bytes, then a clean frame
      send_byte(8'h5A);
      send_byte(8'hC3);
      pulse_rst();
      run_vector(1);

      // Reset in the middle of encoding abandons the frame
      for (int k = 0; k < FB; k++) send_byte(vecs[2].din[k]);
      repeat (6) @(posedge clk);
      pulse_rst();
      v0 = valid_cnt;
      t0 = tx_cnt;
      repeat (80) @(posedge clk);
      @(negedge clk);
      check("abort_no_enc_valid", valid_cnt - v0, 0);
      check("abort_no_tx_start", tx_cnt - t0, 0);
      check("abort_idle", busy, 0);
      run_vector(2);

`ifdef CODEC_SEQ_TIMEOUT_EN
      t0 = tx_cnt;
      send_byte(vecs[0].din[0]);
      send_byte(vecs[0].din[1]);
      repeat (49) @(posedge clk);
      #1 check("timeout_not_yet", busy, 1);
      @(posedge clk);
      #1 check("timeout_idle", busy, 0);
      repeat (20) @(posedge clk);
      #1 check("timeout_no_tx", tx_cnt - t0, 0);
      run_vector(0);
`else
      busy_hold = 0;
      push_exp(0);
      d0 = done_cnt;
      send_byte(vecs[0].din[0]);
      send_byte(vecs[0].din[1]);
      repeat (60) @(posedge clk);
      #1 check("collect_waits", busy, 1);
      send_byte(vecs[0].din[2]);
      send_byte(vecs[0].din[3]);
      wait_done(d0, 5000);
      check("collect_wait_scoreboard", exp_q.size(), 0);
`endif

      check("final_scoreboard", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/codec_uart_sequencer.md
CODEC_UART_SEQUENCER -- requirements
Module: codec_uart_sequencer

Interface
REQ-001 SHALL have parameter FRAME_BYTES, default 4, meaning received bytes per frame (range 1..8).
REQ-002 SHALL have parameter CONSTRAINT_LEN, default 3, meaning value driven on k_sel (range 3..6).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning inter-byte timeout in clk cycles.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port rx_data_ready, input, 1, one-cycle strobe from the UART receiver.
REQ-007 SHALL have port rx_data, input, 8, receiver byte, valid with rx_data_ready.
REQ-008 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-009 SHALL have port tx_start, output, 1, one-cycle transmit request.
REQ-010 SHALL have port tx_data, output, 8, byte to transmit; held stable from tx_start until tx_busy falls.
REQ-011 SHALL have port enc_clear, output, 1, one-cycle encoder state clear.
REQ-012 SHALL have port enc_valid, output, 1, one-cycle strobe qualifying enc_bit.
REQ-013 SHALL have port enc_bit, output, 1, unencoded bit to the encoder.
REQ-014 SHALL have port enc_out, input, 2, encoder output pair, sampled exactly 1 cycle after enc_valid.
REQ-015 SHALL have port k_sel, output, 3, constant CONSTRAINT_LEN[2:0].
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-017 SHALL have port frame_done, output, 1, one-cycle pulse after the last encoded byte is accepted.
REQ-018 SHALL have port overrun, output, 1, sticky flag: a byte was dropped.

Function
REQ-019 SHALL implement states IDLE, COLLECT, ENCODE, SEND.
REQ-020 IDLE: rx_data_ready stores the byte into buffer slot 0, byte count = 1, then go to COLLECT (or straight to ENCODE if FRAME_BYTES=1).
REQ-021 COLLECT: each rx_data_ready stores the byte into slot count, count+1; when count reaches FRAME_BYTES go to ENCODE.
REQ-022 ENCODE entry: pulse enc_clear for 1 cycle; next cycle start bit issue.
REQ-023 ENCODE SHALL issue 8*FRAME_BYTES bits, byte 0 first, LSB first, one enc_valid every 2 cycles (issue, capture).
REQ-024 Each captured enc_out SHALL be packed 2 bits per step, LSB first (enc_out[0] lower), giving 2*FRAME_BYTES output bytes.
REQ-025 After the last capture go to SEND.
REQ-026 SEND: when tx_busy=0 and no pending request, drive tx_data and pulse tx_start; ignore tx_busy the cycle after tx_start; next byte only after tx_busy returns to 0.
REQ-027 After the last tx_start and the subsequent tx_busy fall: pulse frame_done, return to IDLE.
REQ-028 rx_data_ready in ENCODE or SEND SHALL drop the byte and set overrun; overrun clears only on rst.
REQ-029 rx_data_ready coincident with the COLLECT->ENCODE transition cycle counts as ENCODE (dropped).

Reset
REQ-030 rst SHALL force IDLE, count=0, buffers=0, tx_start=0, tx_data=0, enc_clear=0, enc_valid=0, enc_bit=0, frame_done=0, overrun=0, timeout counter=0.
REQ-031 rst asserted mid-frame SHALL abandon the frame with no further tx_start or enc_valid.

Configuration
REQ-032 SHALL support macro CODEC_SEQ_TIMEOUT_EN; when defined: in COLLECT, TIMEOUT_CYCLES cycles without rx_data_ready discards the partial frame and returns to IDLE; counter restarts on every byte.
REQ-033 Without CODEC_SEQ_TIMEOUT_EN, COLLECT SHALL wait indefinitely and TIMEOUT_CYCLES is unused.

Structure
REQ-034 SHALL place the state enum type and the MAX_FRAME_BYTES=8 constant in package codec_seq_pkg.
REQ-035 SHALL use sub-module codec_seq_bitpacker, which serializes the input buffer and packs encoder pairs into output bytes.

Verification (bench uses an encoder stub with enc_out = {bit,bit}, 1-cycle latency)
REQ-036 Receive 0x01,0x00,0x00,0x00: TX sequence is 0x03 followed by 7x 0x00, then frame_done.
REQ-037 Receive 0xFF,0xA5,0x00,0x0F: TX sequence is 0xFF,0xFF,0x33,0xCC,0x00,0x00,0xFF,0x00.
REQ-038 Send a 5th byte while in SEND: byte dropped, overrun=1, current frame output unchanged.
REQ-039 Hold tx_busy=1 for 100 cycles after each start: exactly 8 tx_start pulses, none while busy.
REQ-040 Assert rst after 2 bytes: busy=0 next cycle; a new 4-byte frame then encodes correctly.
REQ-041 With CODEC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=50: 2 bytes then 50 idle cycles gives IDLE with no tx_start.
